// File: rtl/draw_pkg.sv
// Shared state types, colour table and message ROM for draw_seq.
// Build with DRAW_GRADIENT_EN defined to append a position-dependent gradient colour.
package draw_pkg;

   typedef enum logic {FILL, DONE} raster_st_e;
   typedef enum logic [1:0] {IDLE, ERASE, WRITE} text_st_e;

   localparam logic [7:0] SPACE = 8'h20;
   localparam int IDX_W = 3;

`ifdef DRAW_GRADIENT_EN
   localparam int N_COLOURS = 7;
`else
   localparam int N_COLOURS = 6;
`endif
   localparam int GRAD_IDX = 6;

   // {r,g,b} channel-on flags; a set flag drives that channel to full scale.
   localparam logic [2:0] C_WHITE   = 3'b111;
   localparam logic [2:0] C_CYAN    = 3'b011;
   localparam logic [2:0] C_RED     = 3'b100;
   localparam logic [2:0] C_MAGENTA = 3'b101;
   localparam logic [2:0] C_GREEN   = 3'b010;
   localparam logic [2:0] C_YELLOW  = 3'b110;

   function automatic logic [2:0] colour_flags(input logic [IDX_W-1:0] idx);
      case (idx)
         3'd0:    return C_WHITE;
         3'd1:    return C_CYAN;
         3'd2:    return C_RED;
         3'd3:    return C_MAGENTA;
         3'd4:    return C_GREEN;
         3'd5:    return C_YELLOW;
         default: return 3'b000;
      endcase
   endfunction

   // Character 0 is the leftmost character of each string.
   localparam int MSG_ROM_LEN = 32;
   localparam logic [8*MSG_ROM_LEN-1:0] MSG0 = "HELLO, WORLD! DRAW_SEQ TEXT DEMO";
   localparam logic [8*MSG_ROM_LEN-1:0] MSG1 = "VGA FRAMEBUFFER ENGINE BANK ONE!";

   function automatic logic [7:0] msg_char(input logic bank, input int unsigned i);
      int unsigned k;
      k = i % MSG_ROM_LEN;
      return bank ? MSG1[8*(MSG_ROM_LEN-1-k) +: 8] : MSG0[8*(MSG_ROM_LEN-1-k) +: 8];
   endfunction

endpackage

// File: rtl/key_edge.sv
// Two-flop synchroniser for an active-low key with a one-cycle falling-edge pulse.
// Flops reset to "released" so a key held through reset never produces an edge.
module key_edge (
   input  logic CLK,
   input  logic NRST,
   input  logic key_n,
   output logic pressed,
   output logic fall
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   always_comb begin
      meta_d = key_n;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   always_ff @(posedge CLK) begin
      if (!NRST) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign pressed = ~sync_q;
   assign fall    = prev_q & ~sync_q;

endmodule

// File: rtl/draw_seq.sv
// Raster colour-fill engine and banked text-placement engine driven from board keys/switches.
// Defining DRAW_GRADIENT_EN adds a seventh, gradient entry to the raster colour table.
module draw_seq
   import draw_pkg::*;
#(
   parameter int XW      = 8,
   parameter int YW      = 8,
   parameter int CW      = 3,
   parameter int DWELL_W = 24,
   parameter int CXW     = 5,
   parameter int CYW     = 4,
   parameter int MSG_LEN = 8
) (
   input  logic           CLK,
   input  logic           NRST,
   input  logic [9:0]     SW,
   input  logic [3:0]     KEY,
   output logic [XW-1:0]  X,
   output logic [YW-1:0]  Y,
   output logic [CW-1:0]  R,
   output logic [CW-1:0]  G,
   output logic [CW-1:0]  B,
   output logic           WE,
   output logic [CXW-1:0] CX,
   output logic [CYW-1:0] CY,
   output logic [7:0]     CHAR,
   output logic           CWE
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COLOURS - 1);
   localparam logic [CXW-1:0]   LAST_I   = CXW'(MSG_LEN - 1);

   logic restart_edge, pause_lvl, place_edge;
   logic restart_lvl_unused, pause_edge_unused, place_lvl_unused, key3_unused;

   key_edge u_key_restart (.CLK(CLK), .NRST(NRST), .key_n(KEY[0]), .pressed(restart_lvl_unused), .fall(restart_edge));
   key_edge u_key_pause   (.CLK(CLK), .NRST(NRST), .key_n(KEY[1]), .pressed(pause_lvl),          .fall(pause_edge_unused));
   key_edge u_key_place   (.CLK(CLK), .NRST(NRST), .key_n(KEY[2]), .pressed(place_lvl_unused),   .fall(place_edge));
   assign key3_unused = KEY[3];

   // ---------------- raster engine ----------------
   raster_st_e          ras_st_q, ras_st_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DWELL_W-1:0]  dwell_q, dwell_d;
   logic [XW+YW-1:0]    addr_q, addr_d;
   logic [XW-1:0]       x_q, x_d;
   logic [YW-1:0]       y_q, y_d;
   logic [3*CW-1:0]     rgb_q, rgb_d;
   logic                we_q, we_d;
   logic [2:0]          flags;
   logic [3*CW-1:0]     rgb_fill;

   always_comb begin
      flags    = colour_flags(idx_q);
      rgb_fill = {{CW{flags[2]}}, {CW{flags[1]}}, {CW{flags[0]}}};
`ifdef DRAW_GRADIENT_EN
      if (idx_q == IDX_W'(GRAD_IDX))
         rgb_fill = {{CW{1'b1}}, addr_q[XW+YW-1 -: CW], addr_q[XW-1 -: CW]};
`endif
   end

   always_comb begin
      ras_st_d = ras_st_q;
      idx_d    = idx_q;
      dwell_d  = dwell_q;
      addr_d   = addr_q;
      x_d      = x_q;
      y_d      = y_q;
      rgb_d    = rgb_q;
      we_d     = 1'b0;
      if (restart_edge) begin
         ras_st_d = FILL;
         idx_d    = '0;
         dwell_d  = '0;
         addr_d   = '0;
         x_d      = '0;
         y_d      = '0;
         rgb_d    = '0;
      end else begin
         unique case (ras_st_q)
            FILL: if (!pause_lvl) begin
               we_d       = 1'b1;
               {y_d, x_d} = addr_q;
               rgb_d      = rgb_fill;
               addr_d     = addr_q + (XW+YW)'(1);
               dwell_d    = dwell_q + DWELL_W'(1);
               if (&dwell_q) begin
                  if (idx_q == LAST_IDX) ras_st_d = DONE;
                  else                   idx_d    = idx_q + IDX_W'(1);
               end
            end
            DONE: begin
               x_d   = '0;
               y_d   = '0;
               rgb_d = '0;
            end
            default: ras_st_d = FILL;
         endcase
      end
   end

   // ---------------- text engine ----------------
   text_st_e          txt_st_q, txt_st_d;
   logic [CXW-1:0]    i_q, i_d;
   logic [CXW-1:0]    new_col_q, new_col_d, prev_col_q, prev_col_d, cx_q, cx_d;
   logic [CYW-1:0]    new_row_q, new_row_d, prev_row_q, prev_row_d, cy_q, cy_d;
   logic              bank_q, bank_d;
   logic [7:0]        char_q, char_d;
   logic              cwe_q, cwe_d;

   // The first erase write is issued on the detection cycle itself, so IDLE emits slot 0.
   always_comb begin
      txt_st_d   = txt_st_q;
      i_d        = i_q;
      new_col_d  = new_col_q;
      new_row_d  = new_row_q;
      bank_d     = bank_q;
      prev_col_d = prev_col_q;
      prev_row_d = prev_row_q;
      cx_d       = cx_q;
      cy_d       = cy_q;
      char_d     = char_q;
      cwe_d      = 1'b0;
      unique case (txt_st_q)
         IDLE: if (place_edge) begin
            new_col_d = CXW'(SW[8:4]);
            new_row_d = CYW'(SW[3:0]);
            bank_d    = SW[9];
            cwe_d     = 1'b1;
            cx_d      = prev_col_q;
            cy_d      = prev_row_q;
            char_d    = SPACE;
            if (MSG_LEN == 1) begin
               txt_st_d = WRITE;
               i_d      = '0;
            end else begin
               txt_st_d = ERASE;
               i_d      = CXW'(1);
            end
         end
         ERASE: begin
            cwe_d  = 1'b1;
            cx_d   = prev_col_q + i_q;
            cy_d   = prev_row_q;
            char_d = SPACE;
            if (i_q == LAST_I) begin
               txt_st_d = WRITE;
               i_d      = '0;
            end else begin
               i_d = i_q + CXW'(1);
            end
         end
         WRITE: begin
            cwe_d  = 1'b1;
            cx_d   = new_col_q + i_q;
            cy_d   = new_row_q;
            char_d = msg_char(bank_q, 32'(i_q));
            if (i_q == LAST_I) begin
               txt_st_d   = IDLE;
               i_d        = '0;
               prev_col_d = new_col_q;
               prev_row_d = new_row_q;
            end else begin
               i_d = i_q + CXW'(1);
            end
         end
         default: txt_st_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!NRST) begin
         ras_st_q   <= FILL;
         idx_q      <= '0;
         dwell_q    <= '0;
         addr_q     <= '0;
         x_q        <= '0;
         y_q        <= '0;
         rgb_q      <= '0;
         we_q       <= 1'b0;
         txt_st_q   <= IDLE;
         i_q        <= '0;
         new_col_q  <= '0;
         new_row_q  <= '0;
         bank_q     <= 1'b0;
         prev_col_q <= '0;
         prev_row_q <= '0;
         cx_q       <= '0;
         cy_q       <= '0;
         char_q     <= '0;
         cwe_q      <= 1'b0;
      end else begin
         ras_st_q   <= ras_st_d;
         idx_q      <= idx_d;
         dwell_q    <= dwell_d;
         addr_q     <= addr_d;
         x_q        <= x_d;
         y_q        <= y_d;
         rgb_q      <= rgb_d;
         we_q       <= we_d;
         txt_st_q   <= txt_st_d;
         i_q        <= i_d;
         new_col_q  <= new_col_d;
         new_row_q  <= new_row_d;
         bank_q     <= bank_d;
         prev_col_q <= prev_col_d;
         prev_row_q <= prev_row_d;
         cx_q       <= cx_d;
         cy_q       <= cy_d;
         char_q     <= char_d;
         cwe_q      <= cwe_d;
      end
   end

   assign X         = x_q;
   assign Y         = y_q;
   assign {R, G, B} = rgb_q;
   assign WE        = we_q;
   assign CX        = cx_q;
   assign CY        = cy_q;
   assign CHAR      = char_q;
   assign CWE       = cwe_q;

endmodule
